// File: rtl/conv2d_1_window_fetch.sv
// conv2d_1_window_fetch: streams a plane from BRAM port B and emits 3x3 valid-padding windows
// Reads are credit-limited so every in-flight pixel owns an output FIFO slot until it returns.
module conv2d_1_window_fetch #(
   parameter int IMG_W     = 32,
   parameter int IMG_H     = 32,
   parameter int DATA_W    = 8,
   parameter int RD_LAT    = 1,
   parameter int OUT_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [31:0]       base_addr,
   output logic              busy,
   output logic              done,
   output logic [31:0]       bram_addr,
   output logic              bram_en,
   output logic [3:0]        bram_we,
   output logic [31:0]       bram_din,
   input  logic [31:0]       bram_dout,
   output logic              win_valid,
   input  logic              win_ready,
   output logic [9*DATA_W-1:0] win_data,
   output logic              win_last
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int AW = $clog2(OUT_DEPTH);
   localparam int NW = $clog2(OUT_DEPTH + 1);
   localparam int WW = 9 * DATA_W;
   localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
   localparam logic [NW-1:0] DEPTH  = NW'(OUT_DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
   state_t state;
   logic [31:0] addr;
   logic [CW-1:0] c, rc;
   logic [RW-1:0] r, rr;
   logic [RD_LAT-1:0] rd_pipe;
   logic [NW-1:0] outstanding, count;
   logic [AW-1:0] wp, rp;
   logic [DATA_W-1:0] lb0 [IMG_W];
   logic [DATA_W-1:0] lb1 [IMG_W];
   logic [WW-1:0] win_q, next_win;
   logic [WW:0] fifo [OUT_DEPTH];
   logic issue, ret, push, pop, ret_last, unused;
   logic [DATA_W-1:0] pix;

   assign bram_we   = 4'b0000;
   assign bram_din  = 32'd0;
   assign pix       = bram_dout[DATA_W-1:0];
   assign unused    = ^bram_dout[31:DATA_W];
   assign ret       = rd_pipe[RD_LAT-1];
   assign ret_last  = rr == R_LAST && rc == C_LAST;
   assign push      = ret && rr >= RW'(2) && rc >= CW'(2);
   assign win_valid = count != '0;
   assign pop       = win_valid && win_ready;
   assign issue     = state == FETCH && ({1'b0, count} + {1'b0, outstanding} < {1'b0, DEPTH});
   assign {win_last, win_data} = fifo[rp];

   // Window as it looks after the returning pixel's column shifts in on the right.
   always_comb begin
      next_win = '0;
      for (int k = 0; k < 9; k++)
         next_win[k*DATA_W +: DATA_W] = (k % 3 != 2) ? win_q[((k + 1) % 9)*DATA_W +: DATA_W] :
                                        (k == 2) ? lb1[rc] : (k == 5) ? lb0[rc] : pix;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         bram_en     <= 1'b0;
         bram_addr   <= '0;
         addr        <= '0;
         c           <= '0;
         r           <= '0;
         rc          <= '0;
         rr          <= '0;
         rd_pipe     <= '0;
         outstanding <= '0;
         count       <= '0;
         wp          <= '0;
         rp          <= '0;
         win_q       <= '0;
         for (int i = 0; i < IMG_W; i++) begin
            lb0[i] <= '0;
            lb1[i] <= '0;
         end
         for (int i = 0; i < OUT_DEPTH; i++) fifo[i] <= '0;
      end else begin
         done        <= 1'b0;
         bram_en     <= issue;
         rd_pipe     <= RD_LAT'({rd_pipe, bram_en});
         outstanding <= outstanding + NW'(issue) - NW'(ret);
         count       <= count + NW'(push) - NW'(pop);
         if (issue) begin
            bram_addr <= addr;
            addr      <= addr + 32'd4;
            c         <= (c == C_LAST) ? '0 : c + CW'(1);
            r         <= (c == C_LAST) ? r + RW'(1) : r;
         end
         case (state)
            IDLE: if (start) begin
               state <= FETCH;
               busy  <= 1'b1;
               addr  <= base_addr;
               c     <= '0;
               r     <= '0;
               rc    <= '0;
               rr    <= '0;
            end
            FETCH: if (issue && c == C_LAST && r == R_LAST) state <= DRAIN;
            DRAIN: if (outstanding == '0 && count == '0) begin
               state <= DONE;
               done  <= 1'b1;
               busy  <= 1'b0;
            end
            DONE: state <= IDLE;
         endcase
         if (ret) begin
            rc      <= (rc == C_LAST) ? '0 : rc + CW'(1);
            rr      <= (rc == C_LAST) ? rr + RW'(1) : rr;
            lb1[rc] <= lb0[rc];
            lb0[rc] <= pix;
            win_q   <= next_win;
         end
         if (push) begin
            fifo[wp] <= {ret_last, next_win};
            wp       <= wp + AW'(1);
         end
         if (pop) rp <= rp + AW'(1);
      end
   end
endmodule

// File: tb/tb_conv2d_1_window_fetch.sv
// tb_conv2d_1_window_fetch: directed checks on a 4x4/RD_LAT=1 instance and a 32x32/RD_LAT=2 instance
module tb_conv2d_1_window_fetch;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic a_start = 0, a_busy, a_done, a_bram_en, a_win_valid, a_win_ready = 1, a_win_last;
   logic [31:0] a_base_addr = 0, a_bram_addr, a_bram_din, a_bram_dout = 0;
   logic [3:0] a_bram_we;
   logic [71:0] a_win_data;
   logic b_start = 0, b_busy, b_done, b_bram_en, b_win_valid, b_win_ready = 1, b_win_last;
   logic [31:0] b_base_addr = 0, b_bram_addr, b_bram_din, b_bram_dout = 0, b_d1 = 0;
   logic [3:0] b_bram_we;
   logic [71:0] b_win_data;

   conv2d_1_window_fetch #(.IMG_W(4), .IMG_H(4), .DATA_W(8), .RD_LAT(1), .OUT_DEPTH(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .base_addr(a_base_addr), .busy(a_busy), .done(a_done),
      .bram_addr(a_bram_addr), .bram_en(a_bram_en), .bram_we(a_bram_we), .bram_din(a_bram_din),
      .bram_dout(a_bram_dout), .win_valid(a_win_valid), .win_ready(a_win_ready), .win_data(a_win_data),
      .win_last(a_win_last));

   conv2d_1_window_fetch #(.IMG_W(32), .IMG_H(32), .DATA_W(8), .RD_LAT(2), .OUT_DEPTH(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .base_addr(b_base_addr), .busy(b_busy), .done(b_done),
      .bram_addr(b_bram_addr), .bram_en(b_bram_en), .bram_we(b_bram_we), .bram_din(b_bram_din),
      .bram_dout(b_bram_dout), .win_valid(b_win_valid), .win_ready(b_win_ready), .win_data(b_win_data),
      .win_last(b_win_last));

   int n_checks = 0, n_pass = 0, cyc = 0;
   int a_mode = 0, a_n = 0, a_addr_n = 0, a_done_cnt = 0, a_last_cnt = 0;
   int b_mode = 0, b_n = 0, b_addr_n = 0, b_done_cnt = 0, b_last_cnt = 0, b_en_cnt = 0;
   logic [31:0] a_base_m = 0, b_base_m = 0;
   logic [7:0] bmem [1024];

   localparam int A_WIN [4][9] = '{'{0, 1, 2, 4, 5, 6, 8, 9, 10}, '{1, 2, 3, 5, 6, 7, 9, 10, 11},
                                   '{4, 5, 6, 8, 9, 10, 12, 13, 14}, '{5, 6, 7, 9, 10, 11, 13, 14, 15}};

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [71:0] a_exp(input int n);
      logic [71:0] v = '1;
      if (n < 4) for (int k = 0; k < 9; k++) v[k*8 +: 8] = 8'(A_WIN[n][k]);
      return v;
   endfunction

   function automatic logic [71:0] b_exp(input int n);
      logic [71:0] v = '1;
      if (n < 900) for (int k = 0; k < 9; k++) v[k*8 +: 8] = bmem[(n / 30 + k / 3) * 32 + n % 30 + k % 3];
      return v;
   endfunction

   // BRAM port B models: pixel = word offset from plane base (a), random plane (b)
   always @(posedge clk) begin
      if (a_bram_en) a_bram_dout <= (a_bram_addr - a_base_m) >> 2;
      if (b_bram_en) b_d1 <= {24'd0, bmem[10'((b_bram_addr - b_base_m) >> 2)]};
      b_bram_dout <= b_d1;
   end

   always @(negedge clk) begin
      if (a_bram_en) begin
         check("a_addr", a_bram_addr, a_base_m + 32'(4 * a_addr_n));
         a_addr_n++;
      end
      if (a_win_valid) begin
         check("a_win", a_win_data, a_exp(a_n));
         check("a_last", a_win_last, a_n == 3);
         if (a_win_ready) begin
            if (a_win_last) a_last_cnt++;
            a_n++;
         end
      end
      if (a_done) a_done_cnt++;
      if (b_bram_en) begin
         check("b_addr", b_bram_addr, b_base_m + 32'(4 * b_addr_n));
         b_addr_n++;
         b_en_cnt++;
      end
      check("b_we_din", {b_bram_we, b_bram_din}, 0);
      if (b_win_valid) begin
         check("b_win", b_win_data, b_exp(b_n));
         check("b_last", b_win_last, b_n == 899);
         if (b_win_ready) begin
            if (b_win_last) b_last_cnt++;
            b_n++;
         end
      end
      if (b_done) b_done_cnt++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      cyc++;
      a_win_ready = a_mode == 0 ? 1'b1 : a_mode == 1 ? (cyc % 4 == 0) : 1'b0;
      b_win_ready = b_mode == 0 ? 1'b1 : b_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input bit big, input string tag);
      int i = 0;
      do begin
         @(negedge clk);
         i++;
      end while (!(big ? b_done : a_done) && i < 20000);
      check({tag, "_done_seen"}, i < 20000, 1);
      tick();
   endtask

   task automatic run_a(input int mode, input bit ghost, input string tag);
      int d0 = a_done_cnt;
      a_mode = mode; a_n = 0; a_addr_n = 0; a_last_cnt = 0; a_base_m = 32'h100;
      a_base_addr = 32'h100; a_start = 1; tick(); a_start = 0;
      if (ghost) begin
         tick(3);
         a_base_addr = 32'hDEAD0000; a_start = 1; tick(); a_start = 0;
      end
      if (mode == 2) begin
         tick(20);
         a_mode = 0;
      end
      wait_done(0, tag);
      check({tag, "_nwin"}, a_n, 4);
      check({tag, "_nlast"}, a_last_cnt, 1);
      check({tag, "_nreads"}, a_addr_n, 16);
      check({tag, "_ndone"}, a_done_cnt, d0 + 1);
      check({tag, "_busy"}, a_busy, 0);
   endtask

   task automatic run_b(input logic [31:0] base, input bit stall, input string tag);
      int d0 = b_done_cnt, e0;
      b_mode = stall ? 2 : 1; b_n = 0; b_addr_n = 0; b_last_cnt = 0; b_base_m = base;
      b_base_addr = base; b_start = 1; tick(); b_start = 0;
      if (stall) begin
         tick(90);
         e0 = b_en_cnt;
         tick(20);
         check({tag, "_credit_stall"}, b_en_cnt - e0, 0);
         check({tag, "_fifo_full"}, b_win_valid, 1);
         b_mode = 1;
      end
      wait_done(1, tag);
      check({tag, "_nwin"}, b_n, 900);
      check({tag, "_nlast"}, b_last_cnt, 1);
      check({tag, "_nreads"}, b_addr_n, 1024);
      check({tag, "_ndone"}, b_done_cnt, d0 + 1);
   endtask

   initial begin
      int i, e0, d0;
      for (int k = 0; k < 1024; k++) bmem[k] = 8'($urandom);
      tick(3);
      rst_n = 1;
      tick(2);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      check("rst_en", a_bram_en, 0);
      check("rst_addr", a_bram_addr, 0);
      check("rst_valid", a_win_valid, 0);
      check("rst_last", a_win_last, 0);
      check("rst_data", a_win_data, 0);
      check("rst_b_busy", b_busy, 0);
      run_a(0, 0, "a_basic");
      run_a(1, 0, "a_toggle");
      run_a(2, 0, "a_hold");
      run_a(0, 1, "a_ghost");
      run_b(32'h2000, 1, "b_rand");
      b_mode = 1; b_n = 0; b_addr_n = 0; b_base_m = 32'h3000;
      b_base_addr = 32'h3000; b_start = 1; tick(); b_start = 0;
      i = 0;
      while (b_n < 35 && i < 5000) begin
         tick();
         i++;
      end
      check("abort_reached_row2", b_n >= 35, 1);
      rst_n = 0;
      tick(2);
      check("abort_busy", b_busy, 0);
      check("abort_done", b_done, 0);
      check("abort_en", b_bram_en, 0);
      check("abort_addr", b_bram_addr, 0);
      check("abort_valid", b_win_valid, 0);
      check("abort_last", b_win_last, 0);
      check("abort_data", b_win_data, 0);
      e0 = b_en_cnt; d0 = b_done_cnt;
      rst_n = 1;
      tick(10);
      check("abort_no_reads", b_en_cnt - e0, 0);
      check("abort_no_done", b_done_cnt - d0, 0);
      run_b(32'h0, 0, "b_after_rst");
      run_b(32'h4000, 0, "b_b2b_1");
      run_b(32'h8000, 0, "b_b2b_2");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/conv2d_1_window_fetch.md
Name: conv2d_1_window_fetch

Overview:
- Read-side feeder for the Conv_2D_1 stage.
- Streams one input feature-map plane out of the dual-port input/output BRAM through its port B, reading pixels in raster order.
- Builds 3x3 sliding windows (valid padding, stride 1) with two line buffers and a 3x3 shift register.
- Hands the windows to the convolution MAC array over a valid/ready stream.

Parameters:
- IMG_W, 32, plane width in pixels (>=3).
- IMG_H, 32, plane height in pixels (>=3).
- DATA_W, 8, pixel width; pixel = bram_dout[DATA_W-1:0].
- RD_LAT, 1, BRAM read latency in cycles (en at t, dout valid at t+RD_LAT); legal values 1..2.
- OUT_DEPTH, 4, output FIFO depth in windows (power of 2, >=RD_LAT+1).

Ports:
- clk  in  1  single clock; also drives BRAM port B clk.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a plane; ignored while busy=1.
- base_addr  in  32  byte address of pixel (0,0); sampled on an accepted start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the last window has been accepted downstream.
- bram_addr  out  32  port B byte address.
- bram_en  out  1  port B enable.
- bram_we  out  4  port B write enable; constant 4'b0000.
- bram_din  out  32  port B write data; constant 0.
- bram_dout  in  32  port B read data.
- win_valid  out  1  output FIFO not empty.
- win_ready  in  1  downstream accept.
- win_data  out  9*DATA_W  window; slot k = bits [k*DATA_W +: DATA_W], k = 3*row + col, slot 0 = top-left, slot 8 = bottom-right.
- win_last  out  1  high with the final window of a plane.

Behaviour:
- Reset (async assert, sync deassert use): busy=0, done=0, bram_en=0, bram_addr=0, win_valid=0, win_last=0, win_data=0. FIFO, line buffers, counters and outstanding count all cleared.
- A reset mid-plane aborts the plane. No done pulse follows, and there are no spurious BRAM reads after reset.
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE -> FETCH on start: latch base_addr; read counters r=c=0.
  - FETCH: issue one read per cycle when (fifo_count + outstanding) < OUT_DEPTH.
    - bram_en=1, bram_addr = base + 4*(r*IMG_W+c), registered.
    - c wraps at IMG_W-1 and r increments.
    - After issuing pixel (IMG_H-1, IMG_W-1) -> DRAIN.
  - DRAIN: no reads; wait until outstanding=0 and FIFO empty -> DONE.
  - DONE: done=1 for one cycle, busy drops the same cycle -> IDLE.
  - start is accepted in IDLE only; a start arriving in DONE is ignored.
- Credit rule: outstanding counts reads issued but not yet returned. Every read reserves one FIFO slot until its data returns, and the slot is released if that pixel yields no window. The FIFO never overflows.
- Return path, on returning pixel p at column pc, row pr:
  - Shift p into the window bottom row.
  - Rows above come from line buffers 0/1 at column pc.
  - Write p into the line buffers (row pr-1 moves up).
  - If pr>=2 and pc>=2, push a window to the FIFO.
  - Same-cycle FIFO push and pop is legal; count is unchanged.
- Output: (IMG_W-2)*(IMG_H-2) windows per plane in raster order of their top-left pixel. win_last is set on window index (IMG_W-2)*(IMG_H-2)-1.
- win_data and win_last stay stable while win_valid=1 and win_ready=0.
- Throughput: one pixel per cycle with win_ready held high. Stalls occur only from credits.

Test Plan:
- IMG_W=IMG_H=4, RD_LAT=1, pixel = word index (mem[i]=i), win_ready=1, base_addr=0x100.
  - Addresses 0x100..0x13C step 4.
  - Exactly 4 windows: {0,1,2,4,5,6,8,9,10}, {1,2,3,5,6,7,9,10,11}, {4,5,6,8,9,10,12,13,14}, {5,6,7,9,10,11,13,14,15}.
  - win_last on the 4th window, then one done pulse.
- Same setup with win_ready toggled 1-cycle-on / 3-off, and also held low for 20 cycles.
  - Identical window sequence, no drops or duplicates, data stable while stalled.
  - bram_en stops issuing once credits are exhausted.
- RD_LAT=2, IMG_W=IMG_H=32, random pixels, random win_ready.
  - 900 windows matching a reference model; bram_we=0 throughout.
- start pulsed again mid-plane with base_addr=0xDEAD0000 -> ignored; addresses continue from the original base.
- rst_n asserted during the 2nd window row, then a new start with base 0x0 -> all outputs 0 during reset, no done for the aborted plane, new plane produces a correct full window set.
- Back-to-back planes: start issued the cycle after done -> second plane accepted, window count 900 again, win_last once per plane.
